// File: rtl/divider_radix4_quotient_pkg.sv
// Shared constants and types for the radix-4 restoring divider.
// Provides the default operand width, the derived iteration count,
// the FSM state encoding and the iteration-counter width helper.
package divider_pkg;

  // Default operand / quotient / remainder width (must be even)
  localparam int DEF_DIV_SIZE = 110;

  // Default iteration count: two quotient bits retired per step
  localparam int DEF_N_ITER = DEF_DIV_SIZE / 2;

  // Controller states: idle waiting for en, or iterating
  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit)
  function automatic int cnt_width(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_N_ITER);

endpackage

// File: rtl/divider_radix4_quotient_digit_select.sv
// Radix-4 digit selection: picks k in 0..3 as the largest k with k*D1 <= T
// and returns the partial remainder T - k*D1. Purely combinational, so the
// compare/subtract chain can be timed and tested on its own.
module radix4_digit_select
  import divider_pkg::*;
#(
  parameter int W = DEF_DIV_SIZE
) (
  input  logic [W+1:0] i_t,
  input  logic [W+1:0] i_d1,
  input  logic [W+1:0] i_d3,
  output logic [1:0]   o_k,
  output logic [W-1:0] o_rem
);

  // 2*D1 fits in W+2 bits because D1 < 2^W
  logic [W+1:0] w_d2;
  logic [W+1:0] w_sub;
  logic         w_ge3;
  logic         w_ge2;
  logic         w_ge1;

  assign w_d2  = i_d1 << 1;
  assign w_ge3 = (i_t >= i_d3);
  assign w_ge2 = (i_t >= w_d2);
  assign w_ge1 = (i_t >= i_d1);

  // Priority compare: highest multiple that does not exceed T wins
  always_comb begin
    o_k   = 2'd0;
    w_sub = '0;
    if (w_ge3) begin
      o_k   = 2'd3;
      w_sub = i_d3;
    end else if (w_ge2) begin
      o_k   = 2'd2;
      w_sub = w_d2;
    end else if (w_ge1) begin
      o_k   = 2'd1;
      w_sub = i_d1;
    end
  end

  // Remainder stays below D1 < 2^W, so the top two difference bits are always zero
  assign o_rem = W'(i_t - w_sub);

endmodule

// File: rtl/divider_radix4_quotient.sv
// Sequential radix-4 restoring divider: q = floor(a/b), r = a mod b.
// Latency: en accepted at edge 0 -> done pulse after edge N_ITER.
// en is ignored while busy; results held until the next completion.
module divider_radix4_quotient
  import divider_pkg::*;
#(
  parameter int DIV_SIZE = DEF_DIV_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_SIZE-1:0] a,
  input  logic [DIV_SIZE-1:0] b,
  output logic [DIV_SIZE-1:0] q,
  output logic [DIV_SIZE-1:0] r,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);

  localparam int N_ITER = DIV_SIZE / 2;
  localparam int CNT_W  = cnt_width(N_ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  // Controller and working registers
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIV_SIZE-1:0] r_qw;    // dividend shifting out, quotient shifting in
  logic [DIV_SIZE-1:0] r_rem;   // partial remainder, always < D1
  logic [DIV_SIZE+1:0] r_d1;    // divisor copy
  logic [DIV_SIZE+1:0] r_d3;    // 3 * divisor, precomputed at accept
  logic                r_dz;    // divisor was zero

  // Datapath wires
  logic [DIV_SIZE+1:0] w_t;
  logic [1:0]          w_k;
  logic [DIV_SIZE-1:0] w_rem_next;
  logic [DIV_SIZE-1:0] w_qw_next;
  logic [DIV_SIZE+1:0] w_b_ext;
  logic [DIV_SIZE+1:0] w_b3;

  // Bring the next two dividend bits down into the remainder
  assign w_t       = {r_rem, r_qw[DIV_SIZE-1 -: 2]};
  assign w_qw_next = {r_qw[DIV_SIZE-3:0], w_k};

  // 3*b built as b + 2b at the full W+2 width so it cannot overflow
  assign w_b_ext = {2'b00, b};
  assign w_b3    = w_b_ext + {1'b0, b, 1'b0};

  radix4_digit_select #(
    .W (DIV_SIZE)
  ) u_digit_select (
    .i_t   (w_t),
    .i_d1  (r_d1),
    .i_d3  (r_d3),
    .o_k   (w_k),
    .o_rem (w_rem_next)
  );

  // Controller FSM with registered results; done/busy/q/r all updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_qw     <= '0;
      r_rem    <= '0;
      r_d1     <= '0;
      r_d3     <= '0;
      r_dz     <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-asserted by the last step below
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_qw    <= a;
            r_rem   <= '0;
            r_d1    <= w_b_ext;
            r_d3    <= w_b3;
            r_dz    <= (b == '0);
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_qw  <= w_qw_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            q        <= w_qw_next;
            r        <= w_rem_next;
            div_zero <= r_dz;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider_radix4_quotient.md
Name: divider_radix4_quotient

Overview:
- Sequential radix-4 restoring integer divider: 110-bit dividend / 110-bit divisor, producing 2 quotient bits per cycle.
- Inverse companion of the 110-bit DSP multiplier datapath. It serves reduction and quotient-estimation steps that need q = floor(a/b) and r = a mod b rather than a product.
- Uses the same single-cycle `en` start pulse as the multiplier blocks. Results are registered and flagged by a one-cycle `done` pulse.

Parameters:
- DIV_SIZE, 110, operand/quotient/remainder width; must be even.
- N_ITER, DIV_SIZE/2, iteration count (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start pulse; sampled only when busy=0.
- a  input  DIV_SIZE  dividend; sampled with en.
- b  input  DIV_SIZE  divisor; sampled with en.
- q  output  DIV_SIZE  quotient; held until next completion.
- r  output  DIV_SIZE  remainder; held until next completion.
- busy  output  1  high from the cycle after accepted en until done.
- done  output  1  one-cycle pulse; q/r/div_zero valid on that cycle.
- div_zero  output  1  set with done when b==0; held like q.

Behaviour:
- Reset (async, any state): state=IDLE; q=0, r=0, busy=0, done=0, div_zero=0; internal regs cleared. Reset mid-operation aborts, and no done is issued.
- States:
  - IDLE: on en, go to ITER.
  - ITER: cnt 0..N_ITER-1; after the last step, return to IDLE.
  - done is registered on the IDLE transition; there is no separate DONE state.
- Accept edge (IDLE, en=1):
  - Q ← a; R ← 0 (DIV_SIZE+2 bits); D1 ← b; D3 ← 3*b (DIV_SIZE+2 bits, computed as b+(b<<1)).
  - cnt ← 0; busy ← 1; done ← 0.
  - Latch dz ← (b==0).
- ITER edge:
  - T = {R[DIV_SIZE-1:0], Q[DIV_SIZE-1:DIV_SIZE-2]} (DIV_SIZE+2 bits).
  - Digit k = 3 if T≥D3, else 2 if T≥2*D1, else 1 if T≥D1, else 0.
  - R ← T − k*D1 (invariant R < D1); Q ← {Q[DIV_SIZE-3:0], k}.
  - cnt ← cnt+1.
- Last step (cnt==N_ITER-1), on the same edge:
  - q ← new Q; r ← new R[DIV_SIZE-1:0]; div_zero ← dz.
  - done ← 1; busy ← 0; state ← IDLE.
- Latency: en sampled at edge 0 gives done high after edge N_ITER (55 for defaults). Throughput is one division per N_ITER+1 cycles min; back-to-back en on the done cycle is accepted.
- done is high exactly one cycle. It is cleared on the next edge regardless of en.
- en while busy=1: ignored. a/b are not re-sampled and the in-flight operation is unaffected.
- Divide by zero (b==0): the datapath naturally yields k=3 every step, so q=all-ones and r=a. div_zero=1 is flagged; no special casing and same latency.
- a<b: q=0, r=a. a==b≠0: q=1, r=0.
- a/b may change freely after the accept edge; the block works only from internal copies.
- Comparisons and subtractions are unsigned at DIV_SIZE+2 bits; no overflow is possible given R<D1.

Decomposition:
- Shared package divider_pkg:
  - DIV_SIZE default; N_ITER = DIV_SIZE/2.
  - State encoding: IDLE=1'b0, ITER=1'b1.
  - Counter width = clog2(N_ITER).
- One natural sub-module: radix4_digit_select. It is combinational and takes T, D1, D3, returning k[1:0] and the next R. This keeps the compare/subtract chain isolated for timing and unit test.

Test Plan:
1. a=1000, b=7, en pulse → done exactly 55 cycles after the accept edge; q=142, r=6, div_zero=0; busy high for cycles 1..55 only.
2. a=2^110−1, b=1 → q=2^110−1, r=0. Then a=2^110−1, b=2^110−1 → q=1, r=0.
3. a=5, b=0 → q=all-ones, r=5, div_zero=1. The next op with a=9, b=3 → q=3, r=0, div_zero=0.
4. Start a=100, b=9. Pulse en with a=1, b=1 at cycle 20 → ignored; result q=11, r=1. A new en on the done cycle with a=64, b=8 → accepted; q=8, r=0 after 55 more cycles.
5. Assert rst at cycle 30 of an op → q, r, busy, done, div_zero go 0 immediately (async) and no done pulse follows. After release, a=3, b=4 → q=0, r=3.
6. Random 10k pairs (b≠0) vs reference model → q*b+r==a and r<b.
